// File: rtl/rf_corr_pkg.sv
// rtl/rf_corr_pkg.sv - shared state type and width helper for the RF correlator bank
package rf_corr_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    SEARCH  = 1'b1
  } corr_state_e;

  // Bits needed to hold an agreement count from 0 up to and including w.
  function automatic int score_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/rf_correlator_bank_corr_score.sv
// rtl/rf_correlator_bank_corr_score.sv - combinational bit-agreement counter
module corr_score
  import rf_corr_pkg::*;
#(
  parameter int W = 32,
  localparam int SW = score_w(W)
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [SW-1:0] score
);

  // Count positions where a and b agree (W minus the Hamming distance).
  always_comb begin
    score = '0;
    for (int i = 0; i < W; i++) begin
      score = score + SW'(a[i] ~^ b[i]);
    end
  end

endmodule

// File: rtl/rf_correlator_bank.sv
// rtl/rf_correlator_bank.sv - serial frame collector with sequential best-match reference search
module rf_correlator_bank
  import rf_corr_pkg::*;
#(
  parameter int W      = 32,
  parameter int N      = 16,
  parameter int THRESH = 28,
  localparam int IW    = $clog2(N),
  localparam int SW    = score_w(W)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Bit_stream,
  input  logic          Bit_valid,
  input  logic          ref_we,
  input  logic [IW-1:0] ref_addr,
  input  logic [W-1:0]  ref_data,
  output logic          busy,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic [SW-1:0] out_score,
  output logic          out_match,
  output logic          overrun
);

  localparam int CW = $clog2(W);

  corr_state_e   state, state_next;
  logic [W-1:0]  shift_reg;
  logic [W-1:0]  frame_reg;
  logic [CW-1:0] bit_cnt;
  logic [W-1:0]  ref_bank [N];
  logic [IW-1:0] ptr;
  logic [SW-1:0] best_score;
  logic [IW-1:0] best_idx;
  logic [SW-1:0] cur_score;
  logic [SW-1:0] final_score;
  logic [IW-1:0] final_idx;
  logic          frame_done;
  logic          last_cmp;
  logic          take_cur;
  logic          addr_ok;

  assign frame_done  = Bit_valid && (bit_cnt == CW'(W - 1));
  assign last_cmp    = (state == SEARCH) && (ptr == IW'(N - 1));
  // Entry 0 always seeds the tracker; later entries need a strictly better score,
  // so ties resolve to the lowest index.
  assign take_cur    = (ptr == '0) || (cur_score > best_score);
  assign final_score = take_cur ? cur_score : best_score;
  assign final_idx   = take_cur ? ptr : best_idx;
  assign addr_ok     = ({1'b0, ref_addr} < (IW + 1)'(N));
  assign busy        = (state == SEARCH);

  corr_score #(.W(W)) u_score (
    .a     (frame_reg),
    .b     (ref_bank[ptr]),
    .score (cur_score)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= COLLECT;
    else       state <= state_next;
  end

  // Next state: start a search on a completed frame, return after the last entry.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (frame_done) state_next = SEARCH;
      SEARCH:  if (ptr == IW'(N - 1)) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Bit collection runs regardless of state; the register clears as each frame completes.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (Bit_valid) begin
      if (frame_done) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else begin
        shift_reg <= {Bit_stream, shift_reg[W-1:1]};
        bit_cnt   <= bit_cnt + CW'(1);
      end
    end
  end

  // Snapshot a completed frame if idle; a frame completing mid-search is dropped and flagged.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      frame_reg <= '0;
      overrun   <= 1'b0;
    end else if (frame_done) begin
      if (state == COLLECT) frame_reg <= {Bit_stream, shift_reg[W-1:1]};
      else                  overrun   <= 1'b1;
    end
  end

  // Walk the bank one entry per cycle, tracking the best score and its index.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr        <= '0;
      best_score <= '0;
      best_idx   <= '0;
    end else if (state == COLLECT) begin
      if (frame_done) begin
        ptr        <= '0;
        best_score <= '0;
        best_idx   <= '0;
      end
    end else begin
      best_score <= final_score;
      best_idx   <= final_idx;
      ptr        <= last_cmp ? '0 : ptr + IW'(1);
    end
  end

  // Publish the final best with a one-cycle strobe; result fields hold until the next one.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_score <= '0;
      out_match <= 1'b0;
    end else begin
      out_valid <= last_cmp;
      if (last_cmp) begin
        out_idx   <= final_idx;
        out_score <= final_score;
        out_match <= (final_score >= SW'(THRESH));
      end
    end
  end

  // Reference bank: writes land in any state; an in-flight compare sees the pre-write value.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) ref_bank[i] <= '0;
    end else if (ref_we && addr_ok) begin
      ref_bank[ref_addr] <= ref_data;
    end
  end

endmodule

// File: tb/tb_rf_correlator_bank.sv
// tb/tb_rf_correlator_bank.sv - randomized self-checking bench for rf_correlator_bank
module tb_rf_correlator_bank;

  localparam int W = 32;
  localparam int N = 16;
  localparam int THRESH = 28;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Bit_stream = 1'b0;
  logic        Bit_valid = 1'b0;
  logic        ref_we = 1'b0;
  logic [3:0]  ref_addr = '0;
  logic [31:0] ref_data = '0;
  logic        busy, out_valid, out_match, overrun;
  logic [3:0]  out_idx;
  logic [5:0]  out_score;

  logic        b40_stream = 1'b0;
  logic        b40_valid = 1'b0;
  logic        ref_we40 = 1'b0;
  logic [5:0]  ref_addr40 = '0;
  logic [31:0] ref_data40 = '0;
  logic        busy40, out_valid40, out_match40, overrun40;
  logic [5:0]  out_idx40;
  logic [5:0]  out_score40;

  int vectors = 0;
  int miscompares = 0;
  bit rand_wr = 1'b0;

  always #5 Clock = ~Clock;

  rf_correlator_bank #(.W(W), .N(N), .THRESH(THRESH)) dut (
    .Clock(Clock), .Reset(Reset), .Bit_stream(Bit_stream), .Bit_valid(Bit_valid),
    .ref_we(ref_we), .ref_addr(ref_addr), .ref_data(ref_data),
    .busy(busy), .out_valid(out_valid), .out_idx(out_idx), .out_score(out_score),
    .out_match(out_match), .overrun(overrun)
  );

  rf_correlator_bank #(.W(32), .N(40), .THRESH(THRESH)) dut40 (
    .Clock(Clock), .Reset(Reset), .Bit_stream(b40_stream), .Bit_valid(b40_valid),
    .ref_we(ref_we40), .ref_addr(ref_addr40), .ref_data(ref_data40),
    .busy(busy40), .out_valid(out_valid40), .out_idx(out_idx40), .out_score(out_score40),
    .out_match(out_match40), .overrun(overrun40)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bits are gathered into a frame in arrival order; at the
  // snapshot the bank contents are captured, then patched for writes that land
  // before the entry's own compare edge; the result is the arg-max (lowest index
  // on ties) over that view, due N edges after the snapshot.
  logic [31:0] m_ref  [16];
  logic [31:0] m_used [16];
  logic [31:0] m_acc, m_frame;
  int          m_n, e, t_snap, m_bs, m_bi, m_s;
  bit          m_srch, m_was;
  bit          x_valid, x_match, x_ov;
  logic [3:0]  x_idx;
  logic [5:0]  x_score;

  always @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < 16; k++) m_ref[k] = '0;
      m_n = 0; e = 0; t_snap = 0; m_srch = 0;
      x_valid = 0; x_match = 0; x_ov = 0; x_idx = '0; x_score = '0;
    end else begin
      m_was = m_srch;
      e++;
      x_valid = 0;
      if (ref_we) begin
        m_ref[ref_addr] = ref_data;
        if (m_srch && (t_snap + 1 + int'(ref_addr) > e)) m_used[ref_addr] = ref_data;
      end
      if (m_srch && e == t_snap + N) begin
        m_bs = -1; m_bi = 0;
        for (int k = 0; k < N; k++) begin
          m_s = W - $countones(m_used[k] ^ m_frame);
          if (m_s > m_bs) begin m_bs = m_s; m_bi = k; end
        end
        x_valid = 1; x_idx = 4'(m_bi); x_score = 6'(m_bs); x_match = (m_bs >= THRESH);
        m_srch = 0;
      end
      if (Bit_valid) begin
        m_acc[m_n] = Bit_stream;
        m_n++;
        if (m_n == W) begin
          m_n = 0;
          if (m_was) x_ov = 1;
          else begin
            m_frame = m_acc; t_snap = e; m_used = m_ref; m_srch = 1;
          end
        end
      end
    end
  end

  // Cycle scoreboard, sampled just after each rising edge.
  always @(posedge Clock) begin
    #1;
    check("sb_busy", busy, m_srch);
    check("sb_out_valid", out_valid, x_valid);
    check("sb_out_idx", out_idx, x_idx);
    check("sb_out_score", out_score, x_score);
    check("sb_out_match", out_match, x_match);
    check("sb_overrun", overrun, x_ov);
  end

  task automatic drive(input logic b, input logic v);
    @(negedge Clock);
    Bit_stream = b;
    Bit_valid  = v;
    if (rand_wr && $urandom_range(0, 7) == 0) begin
      ref_we = 1'b1; ref_addr = 4'($urandom); ref_data = $urandom;
    end else begin
      ref_we = 1'b0;
    end
  endtask

  task automatic stream_word(input logic [31:0] w, input int gap_pct);
    for (int i = 0; i < W; i++) begin
      while ($urandom_range(0, 99) < gap_pct) drive(1'($urandom_range(0, 1)), 1'b0);
      drive(w[i], 1'b1);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic write_ref(input logic [3:0] a, input logic [31:0] d);
    @(negedge Clock);
    Bit_valid = 1'b0; ref_we = 1'b1; ref_addr = a; ref_data = d;
    @(negedge Clock);
    ref_we = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int idx, input int score, input int match);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 60) begin
      @(negedge Clock);
      k++;
    end
    check({tag, "_seen"}, (k < 60), 1);
    if (k < 60) begin
      check({tag, "_idx"}, out_idx, idx);
      check({tag, "_score"}, out_score, score);
      check({tag, "_match"}, out_match, match);
      @(negedge Clock);
      check({tag, "_one_cycle"}, out_valid, 0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge Clock); Reset = 1'b1; Bit_valid = 1'b0; ref_we = 1'b0; b40_valid = 1'b0;
    @(negedge Clock); Reset = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [31:0] fr;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_score", out_score, 0);
    check("rst_out_match", out_match, 0);
    check("rst_overrun", overrun, 0);

    stream_word(32'h0000_0000, 0);
    wait_result("zeros", 0, 32, 1);

    write_ref(4'd5, 32'hDEADBEEF);
    stream_word(32'hDEADBEEF, 0);
    wait_result("deadbeef", 5, 32, 1);

    write_ref(4'd3, 32'h0000FFFF);
    write_ref(4'd9, 32'h0000FFFF);
    stream_word(32'h0000FFFF, 0);
    wait_result("tie_low", 3, 32, 1);

    pulse_reset();
    write_ref(4'd7, 32'hFFFFFFFF);
    stream_word(32'hFFFF000F, 0);
    wait_result("partial", 7, 20, 0);

    // Abort a search at its fourth compare edge; collection had gaps.
    stream_word(32'h1234_5678, 40);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_idx", out_idx, 0);
    check("abort_out_score", out_score, 0);
    @(negedge Clock);
    Reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clock);
      cnt += int'(out_valid);
    end
    check("abort_no_valid", cnt, 0);
    stream_word(32'hDEADBEEF, 0);
    wait_result("refs_cleared", 0, 8, 0);

    // Randomized frames with planted near-matches and writes during collection/search.
    rand_wr = 1'b1;
    for (int f = 0; f < 12; f++) begin
      fr = $urandom;
      for (int j = 0; j < 3; j++)
        write_ref(4'($urandom), fr ^ (32'h1 << $urandom_range(0, 31)) ^ (32'h1 << $urandom_range(0, 31)));
      stream_word(fr, $urandom_range(0, 30));
      repeat (20) drive(1'($urandom_range(0, 1)), 1'b0);
    end
    rand_wr = 1'b0;
    drive(1'b0, 1'b0);

    // N > W: a second back-to-back frame must be dropped.
    pulse_reset();
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge Clock);
      b40_stream = 1'b0; b40_valid = 1'b1;
      cnt += int'(out_valid40);
      if (i == 40) check("n40_no_overrun_yet", overrun40, 0);
    end
    @(negedge Clock);
    b40_valid = 1'b0;
    cnt += int'(out_valid40);
    check("n40_overrun", overrun40, 1);
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      cnt += int'(out_valid40);
    end
    check("n40_one_result", cnt, 1);
    check("n40_idx", out_idx40, 0);
    check("n40_score", out_score40, 32);
    check("n40_match", out_match40, 1);
    check("n40_overrun_sticky", overrun40, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
